// File: rtl/ssram_pin_responder.sv
// ssram_pin_responder: pipelined SSRAM device model on the controller pin bus; SSRAM_RESP_BURST_EN adds 4-word wrap bursts
module ssram_pin_responder #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 19,
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce_n,
  input  logic                  adsc_n,
  input  logic                  adv_n,
  input  logic                  we_n,
  input  logic                  oe_n,
  input  logic [DATA_W/8-1:0]   be_n,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     dq_in,
  output logic [DATA_W-1:0]     dq_out,
  output logic                  dq_oe
);
  localparam int IW = $clog2(DEPTH);
  localparam int BW = DATA_W / 8;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] pd [READ_LAT];
  logic [READ_LAT-1:0] pv;
  logic valid_out;
  logic start, go, wr;
  logic [IW-1:0] idx;
  logic unused;
  assign start = ~ce_n & ~adsc_n;
`ifdef SSRAM_RESP_BURST_EN
  logic burst_act, burst_wr, adv;
  logic [IW-1:0] burst_idx;
  assign adv = ~ce_n & adsc_n & ~adv_n & burst_act;
  assign unused = ^addr;
  always_comb begin
    go  = start | adv;
    wr  = start ? ~we_n : burst_wr;
    idx = start ? addr[IW-1:0] : {burst_idx[IW-1:2], burst_idx[1:0] + 2'd1};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_act <= 1'b0;
      burst_wr  <= 1'b0;
    end else if (go) begin
      burst_act <= 1'b1;
      burst_wr  <= wr;
      burst_idx <= idx;
    end
  end
`else
  assign unused = ^{adv_n, addr};
  always_comb begin
    go  = start;
    wr  = ~we_n;
    idx = addr[IW-1:0];
  end
`endif
  // read captures the pre-write word because both use non-blocking updates on the same edge
  always_ff @(posedge clk) begin
    if (go && wr)
      for (int k = 0; k < BW; k++)
        if (!be_n[k]) mem[idx][k*8 +: 8] <= dq_in[k*8 +: 8];
    pd[0] <= mem[idx];
    for (int i = 1; i < READ_LAT; i++) pd[i] <= pd[i-1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pv        <= '0;
      valid_out <= 1'b0;
      dq_out    <= '0;
    end else begin
      pv[0] <= go & ~wr;
      for (int i = 1; i < READ_LAT; i++) pv[i] <= pv[i-1];
      valid_out <= pv[READ_LAT-1];
      if (pv[READ_LAT-1]) dq_out <= pd[READ_LAT-1];
    end
  end
  assign dq_oe = valid_out & ~oe_n;
endmodule

// File: tb/tb_ssram_pin_responder.sv
// tb_ssram_pin_responder: table-driven directed checks of ssram_pin_responder with default parameters
module tb_ssram_pin_responder;
  logic clk = 1'b0, reset = 1'b1;
  logic ce_n = 1'b1, adsc_n = 1'b1, adv_n = 1'b1, we_n = 1'b1, oe_n = 1'b0;
  logic [3:0] be_n = 4'hF;
  logic [18:0] addr = '0;
  logic [31:0] dq_in = '0, dq_out;
  logic dq_oe;
  int checks = 0, errors = 0;
  typedef struct {
    logic ce_n, adsc_n, adv_n, we_n, oe_n;
    logic [3:0] be_n;
    logic [18:0] addr;
    logic [31:0] din, edq;
    logic eoe;
  } vec_t;
  vec_t q[$];

  ssram_pin_responder dut (
    .clk(clk), .reset(reset), .ce_n(ce_n), .adsc_n(adsc_n), .adv_n(adv_n), .we_n(we_n),
    .oe_n(oe_n), .be_n(be_n), .addr(addr), .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe)
  );

  always #5 clk = ~clk;

  task automatic add(input logic c, s, v, w, o, input logic [3:0] b, input logic [18:0] a,
                     input logic [31:0] d, e, input logic eo);
    vec_t t;
    t.ce_n = c; t.adsc_n = s; t.adv_n = v; t.we_n = w; t.oe_n = o;
    t.be_n = b; t.addr = a; t.din = d; t.edq = e; t.eoe = eo;
    q.push_back(t);
  endtask
  task automatic wr_v(input logic [18:0] a, input logic [31:0] d, input logic [3:0] b, input logic [31:0] e, input logic eo);
    add(0, 0, 1, 0, 0, b, a, d, e, eo);
  endtask
  task automatic rd_v(input logic [18:0] a, input logic [31:0] e, input logic eo);
    add(0, 0, 1, 1, 0, 4'hF, a, 32'h0, e, eo);
  endtask
  task automatic idle_v(input logic o, input logic [31:0] e, input logic eo);
    add(1, 1, 1, 1, o, 4'hF, 19'h0, 32'h0, e, eo);
  endtask
  task automatic adv_v(input logic w, input logic [31:0] d, e, input logic eo);
    add(0, 1, 0, w, 0, 4'h0, 19'h0, d, e, eo);
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t t);
    ce_n = t.ce_n; adsc_n = t.adsc_n; adv_n = t.adv_n; we_n = t.we_n; oe_n = t.oe_n;
    be_n = t.be_n; addr = t.addr; dq_in = t.din;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    ce_n = 1; adsc_n = 1; adv_n = 1; we_n = 1; oe_n = 0; be_n = 4'hF;
  endtask

  initial begin
    wr_v(5, 32'h12345678, 4'h0, 32'h0, 0);
    rd_v(5, 32'h0, 0);
    idle_v(0, 32'h0, 0);
    idle_v(0, 32'h12345678, 1);
    idle_v(0, 32'h12345678, 0);
    wr_v(9, 32'hFFFFFFFF, 4'h0, 32'h12345678, 0);
    wr_v(9, 32'h000000AA, 4'hE, 32'h12345678, 0);
    rd_v(9, 32'h12345678, 0);
    idle_v(0, 32'h12345678, 0);
    idle_v(1, 32'hFFFFFFAA, 0);
    idle_v(0, 32'hFFFFFFAA, 0);
    wr_v(1, 32'h11, 4'h0, 32'hFFFFFFAA, 0);
    wr_v(2, 32'h22, 4'h0, 32'hFFFFFFAA, 0);
    wr_v(3, 32'h33, 4'h0, 32'hFFFFFFAA, 0);
    rd_v(1, 32'hFFFFFFAA, 0);
    rd_v(2, 32'hFFFFFFAA, 0);
    rd_v(3, 32'h11, 1);
    idle_v(0, 32'h22, 1);
    idle_v(0, 32'h33, 1);
    idle_v(0, 32'h33, 0);
    wr_v(1024 + 3, 32'hCAFE0003, 4'h0, 32'h33, 0);
    rd_v(3, 32'h33, 0);
    wr_v(3, 32'h0BADF00D, 4'h0, 32'h33, 0);
    idle_v(0, 32'hCAFE0003, 1);
    idle_v(0, 32'hCAFE0003, 0);
    rd_v(3, 32'hCAFE0003, 0);
    idle_v(0, 32'hCAFE0003, 0);
    idle_v(0, 32'h0BADF00D, 1);
    add(1, 0, 1, 0, 0, 4'h0, 3, 32'h55555555, 32'h0BADF00D, 0);
    add(1, 0, 1, 1, 0, 4'hF, 3, 32'h0, 32'h0BADF00D, 0);
    idle_v(0, 32'h0BADF00D, 0);
    idle_v(0, 32'h0BADF00D, 0);
    rd_v(3, 32'h0BADF00D, 0);
    idle_v(0, 32'h0BADF00D, 0);
    idle_v(0, 32'h0BADF00D, 1);
    wr_v(9, 32'h00000012, 4'hF, 32'h0BADF00D, 0);
    rd_v(9, 32'h0BADF00D, 0);
    idle_v(0, 32'h0BADF00D, 0);
    idle_v(0, 32'hFFFFFFAA, 1);
`ifdef SSRAM_RESP_BURST_EN
    wr_v(4, 32'h40, 4'h0, 32'hFFFFFFAA, 0);
    adv_v(0, 32'h41, 32'hFFFFFFAA, 0);
    adv_v(0, 32'h42, 32'hFFFFFFAA, 0);
    adv_v(0, 32'h43, 32'hFFFFFFAA, 0);
    rd_v(6, 32'hFFFFFFAA, 0);
    adv_v(1, 32'h0, 32'hFFFFFFAA, 0);
    adv_v(1, 32'h0, 32'h42, 1);
    adv_v(1, 32'h0, 32'h43, 1);
    idle_v(0, 32'h40, 1);
    idle_v(0, 32'h41, 1);
    idle_v(0, 32'h41, 0);
`endif

    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("reset dq_oe", {31'b0, dq_oe}, 32'h0);
    chk("reset dq_out", dq_out, 32'h0);
    reset = 0;
    foreach (q[i]) begin
      step(q[i]);
      chk($sformatf("row%0d dq_out", i), dq_out, q[i].edq);
      chk($sformatf("row%0d dq_oe", i), {31'b0, dq_oe}, {31'b0, q[i].eoe});
    end

    // reset one edge after a read start flushes the pipe
    ce_n = 0; adsc_n = 0; we_n = 1; addr = 5; oe_n = 0;
    @(posedge clk);
    #1;
    idle_in();
    reset = 1;
    @(posedge clk);
    #1;
    chk("midreset dq_oe", {31'b0, dq_oe}, 32'h0);
    chk("midreset dq_out", dq_out, 32'h0);
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("postreset%0d dq_oe", k), {31'b0, dq_oe}, 32'h0);
      chk($sformatf("postreset%0d dq_out", k), dq_out, 32'h0);
    end
    ce_n = 0; adsc_n = 0; we_n = 1; addr = 5;
    @(posedge clk);
    #1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("array kept dq_out", dq_out, 32'h12345678);
    chk("array kept dq_oe", {31'b0, dq_oe}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
